rf_multiport_sb: RTL and testbench
==================================

// Module: rf_multiport_sb
// PURPOSE
//  Parametrised register file for the pipelined RISC-V core: NRD combinational read ports, one write port,
//  debug read port, write-first bypass, x0 hardwired zero. Self-initialising via a post-reset sweep FSM
//  (no reset fan-out to the array). Optional per-register busy scoreboard for ID-stage hazard detection.
//  Sits in ID; written from WB.
// PARAMETERS
//  XLEN     32        data width
//  NREG     32        number of registers (power of 2, >=4); AW = $clog2(NREG) (localparam)
//  NRD      2         number of read ports (>=1)
//  SP_INIT  32'h2ffc  value loaded into reg 2 by init sweep
//  GP_INIT  32'h1800  value loaded into reg 3 by init sweep; all other registers load 0
// PORTS
//  clk       in   1         clock, rising edge
//  rstn      in   1         asynchronous reset, active low
//  ready     out  1         1 = RUN (init sweep complete); writes/issues accepted only when 1
//  ra        in   NRD*AW    read addresses, port k = ra[k*AW +: AW]
//  rd        out  NRD*XLEN  read data, port k = rd[k*XLEN +: XLEN]
//  busy      out  NRD       scoreboard busy for register addressed by port k
//  we        in   1         write enable
//  wa        in   AW        write address
//  wd        in   XLEN      write data
//  iss_valid in   1         instruction issued with destination iss_rd (scoreboard set)
//  iss_rd    in   AW        destination register of issued instruction
//  ra_dbg    in   AW        debug read address
//  rd_dbg    out  XLEN      debug read data
// BEHAVIOUR
//  - FSM states INIT, RUN. rstn low (async): state=INIT, idx=0, ready=0, all busy bits=0; array not touched.
//  - INIT: each posedge writes reg[idx] = (idx==2?SP_INIT : idx==3?GP_INIT : 0), idx++; on posedge writing
//    idx==NREG-1, state->RUN, ready->1 (registered). ready rises on the NREG-th posedge after rstn release.
//  - INIT: we and iss_valid ignored (dropped, no side effects); rd, rd_dbg read 0; busy reads 0.
//  - RUN: posedge with we && wa!=0 writes reg[wa]=wd. we with wa==0 is a no-op.
//  - Reads combinational, zero latency: rd_k = (ra_k==0) ? 0 : (we && ready && wa!=0 && wa==ra_k) ? wd : reg[ra_k].
//    Same bypass rule for rd_dbg. Multiple ports may read same address simultaneously; all get identical data.
//  - reg[0] never written by sweep or port value other than 0; always reads 0.
//  - rstn asserted mid-sweep or in RUN: sweep restarts from idx 0 on release; array contents prior to
//    re-sweep are don't-care but never visible (reads gated to 0 until ready).
//  - No overflow/wrap: idx width AW+1 or terminal-compare on NREG-1; idx never wraps to re-sweep in RUN.
// CONFIGURATION
//  RF_SCOREBOARD_EN defined:
//   - busy_q[NREG-1:0], reset 0. RUN posedge: if we&&wa!=0 clear busy_q[wa]; if iss_valid&&iss_rd!=0 set
//     busy_q[iss_rd]. Same register set and cleared same edge: set wins (new producer outstanding).
//   - busy[k] = busy_q[ra_k] && !(we && wa==ra_k && !(iss_valid && iss_rd==ra_k)) (combinational, bypassed
//     clear); busy[k]=0 for ra_k==0. iss_rd==0 never sets a bit.
//  RF_SCOREBOARD_EN undefined: no busy state; busy tied to 0; iss_valid, iss_rd ignored.
// TESTING
//  1 Reset release, NREG=32 -> ready=0 for 31 posedges, 1 after 32nd; then read r2=32'h2ffc, r3=32'h1800, r5=0.
//  2 RUN: we=1,wa=5,wd=32'hdeadbeef, ra port0=5 same cycle -> rd0=32'hdeadbeef combinationally; next cycle
//    we=0 -> rd0=32'hdeadbeef from array; rd_dbg(5) matches.
//  3 we=1,wa=0,wd=32'h1234 -> all ports reading 0 return 0, before and after edge.
//  4 During INIT (cycle 10) we=1,wa=7,wd=32'h55 -> dropped; after ready, r7 reads 0.
//  5 (RF_SCOREBOARD_EN) iss r8 -> busy for ra=8 next cycle; we wa=8 -> busy 0 same cycle (bypass), stays 0;
//    iss r8 + we wa=8 same edge -> busy stays 1. Without macro: busy always 0.
//  6 rstn pulsed low mid-RUN after writing r9=32'hff -> ready drops immediately, reads 0; after re-sweep r9=0.

Source files
------------

// File: rtl/rf_multiport_sb_if.sv
// Bus bundle for rf_multiport_sb: read/write/issue/debug ports.
// The master modport is the core side and the slave modport is the register file side.
interface rf_multiport_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);

    logic                 ready;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*XLEN-1:0]  rd;
    logic [NRD-1:0]       busy;
    logic                 we;
    logic [AW-1:0]        wa;
    logic [XLEN-1:0]      wd;
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic [AW-1:0]        ra_dbg;
    logic [XLEN-1:0]      rd_dbg;

    modport master (
        input  ready, rd, busy, rd_dbg,
        output ra, we, wa, wd, iss_valid, iss_rd, ra_dbg
    );

    modport slave (
        output ready, rd, busy, rd_dbg,
        input  ra, we, wa, wd, iss_valid, iss_rd, ra_dbg
    );
endinterface

// File: rtl/rf_multiport_sb.sv
// Multi-read-port register file: post-reset init sweep, write-first bypass, x0 hardwired to zero.
// Define RF_SCOREBOARD_EN to add the per-register busy scoreboard used for ID-stage hazard checks.
module rf_multiport_sb #(
    parameter int              XLEN    = 32,
    parameter int              NREG    = 32,
    parameter int              NRD     = 2,
    parameter logic [XLEN-1:0] SP_INIT = 32'h2ffc,
    parameter logic [XLEN-1:0] GP_INIT = 32'h1800
) (
    input  logic              clk,
    input  logic              rstn,
    rf_multiport_sb_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   idx, idx_next;
    logic            ready;
    logic            wr_en;
    logic [XLEN-1:0] init_val;
    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // idx wraps to 0 on the final sweep edge but is frozen once in RUN, so no re-sweep.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        if (state == INIT) begin
            idx_next = idx + 1'b1;
            if (idx == AW'(NREG - 1))
                state_next = RUN;
        end
    end

    always_comb begin
        ready = (state == RUN);
        wr_en = ready && bus.we && (bus.wa != '0);
    end

    assign bus.ready = ready;

    always_comb begin
        init_val = '0;
        if (idx == AW'(2))
            init_val = SP_INIT;
        else if (idx == AW'(3))
            init_val = GP_INIT;
    end

    // The array carries no reset; the sweep gives it defined contents before reads are ungated.
    always_ff @(posedge clk) begin
        if (!ready) begin
            if (rstn)
                regs[idx] <= init_val;
        end else if (wr_en) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        if (!ready || a == '0)
            return '0;
        if (wr_en && bus.wa == a)
            return bus.wd;
        return regs[a];
    endfunction

    always_comb begin
        bus.rd = '0;
        for (int k = 0; k < NRD; k++)
            bus.rd[k*XLEN +: XLEN] = read_port(bus.ra[k*AW +: AW]);
        bus.rd_dbg = read_port(bus.ra_dbg);
    end

`ifdef RF_SCOREBOARD_EN
    logic [NREG-1:0] busy_q;
    logic            iss_en;

    assign iss_en = ready && bus.iss_valid && (bus.iss_rd != '0);

    // Set is assigned last so a new producer wins over a retiring one on the same register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            if (wr_en)
                busy_q[bus.wa] <= 1'b0;
            if (iss_en)
                busy_q[bus.iss_rd] <= 1'b1;
        end
    end

    always_comb begin
        bus.busy = '0;
        for (int k = 0; k < NRD; k++) begin
            bus.busy[k] = (bus.ra[k*AW +: AW] != '0) && busy_q[bus.ra[k*AW +: AW]]
                          && !(bus.we && bus.wa == bus.ra[k*AW +: AW]
                               && !(bus.iss_valid && bus.iss_rd == bus.ra[k*AW +: AW]));
        end
    end
`else
    logic unused_iss;

    assign bus.busy   = '0;
    assign unused_iss = ^{bus.iss_valid, bus.iss_rd};
`endif
endmodule

// File: tb/tb_rf_multiport_sb.sv
// Bench for rf_multiport_sb: directed and random stimulus against a behavioural model.
// Expected responses are queued by the driver and compared by an independent monitor.
module tb_rf_multiport_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = $clog2(NREG);
    localparam logic [XLEN-1:0] SP_INIT = 32'h2ffc;
    localparam logic [XLEN-1:0] GP_INIT = 32'h1800;
`ifdef RF_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif
    localparam int MAX_CYC = 5000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rf_multiport_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus();

    rf_multiport_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .SP_INIT(SP_INIT), .GP_INIT(GP_INIT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct packed {
        logic                ready;
        logic [NRD*XLEN-1:0] rd;
        logic [XLEN-1:0]     dbg;
        logic [NRD-1:0]      busy;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    // Stimulus for the current cycle
    logic            s_rstn;
    logic            s_we;
    int              s_wa;
    logic [XLEN-1:0] s_wd;
    logic            s_iss;
    int              s_iss_rd;
    int              s_ra [NRD];
    int              s_dbg;

    // Behavioural model: edges since reset release, architectural registers, outstanding producers
    int              cnt;
    logic [XLEN-1:0] mregs [NREG];
    bit   [NREG-1:0] mbusy;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  done     = 1'b0;

    function automatic logic [XLEN-1:0] mread(input int a);
        if (cnt < NREG || a == 0)
            return '0;
        if (s_we && a == s_wa)
            return s_wd;
        return mregs[a];
    endfunction

    function automatic logic mbusy_rd(input int a);
        if (!SB || a == 0)
            return 1'b0;
        return mbusy[a] && !(s_we && s_wa == a && !(s_iss && s_iss_rd == a));
    endfunction

    task automatic idle();
        s_rstn   = 1'b1;
        s_we     = 1'b0;
        s_wa     = 0;
        s_wd     = '0;
        s_iss    = 1'b0;
        s_iss_rd = 0;
        for (int k = 0; k < NRD; k++) s_ra[k] = 0;
        s_dbg    = 0;
    endtask

    task automatic randomize_inputs(input int amax);
        s_we     = ($urandom_range(0, 1) == 1);
        s_wa     = $urandom_range(0, amax);
        s_wd     = $urandom;
        s_iss    = ($urandom_range(0, 2) == 0);
        s_iss_rd = $urandom_range(0, amax);
        for (int k = 0; k < NRD; k++) s_ra[k] = $urandom_range(0, amax);
        s_dbg    = $urandom_range(0, amax);
    endtask

    task automatic drive(input string tag);
        exp_t e;
        @(negedge clk);
        rstn          = s_rstn;
        bus.we        = s_we;
        bus.wa        = AW'(s_wa);
        bus.wd        = s_wd;
        bus.iss_valid = s_iss;
        bus.iss_rd    = AW'(s_iss_rd);
        for (int k = 0; k < NRD; k++) bus.ra[k*AW +: AW] = AW'(s_ra[k]);
        bus.ra_dbg    = AW'(s_dbg);

        if (!s_rstn) begin
            cnt   = 0;
            mbusy = '0;
        end
        e.ready = (cnt >= NREG);
        e.rd    = '0;
        e.busy  = '0;
        for (int k = 0; k < NRD; k++) begin
            e.rd[k*XLEN +: XLEN] = mread(s_ra[k]);
            e.busy[k]            = mbusy_rd(s_ra[k]);
        end
        e.dbg = mread(s_dbg);
        exp_q.push_back(e);
        tag_q.push_back(tag);

        // Effect of the coming rising edge
        if (s_rstn) begin
            if (cnt < NREG) begin
                cnt++;
                if (cnt == NREG)
                    for (int i = 0; i < NREG; i++)
                        mregs[i] = (i == 2) ? SP_INIT : (i == 3) ? GP_INIT : '0;
            end else begin
                if (s_we && s_wa != 0) begin
                    mregs[s_wa] = s_wd;
                    mbusy[s_wa] = 1'b0;
                end
                if (s_iss && s_iss_rd != 0)
                    mbusy[s_iss_rd] = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Monitor
    initial begin
        exp_t  e;
        string t;
        int    cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check({t, ".ready"}, XLEN'(bus.ready), XLEN'(e.ready));
                for (int k = 0; k < NRD; k++) begin
                    check($sformatf("%s.rd%0d", t, k), bus.rd[k*XLEN +: XLEN], e.rd[k*XLEN +: XLEN]);
                    check($sformatf("%s.busy%0d", t, k), XLEN'(bus.busy[k]), XLEN'(e.busy[k]));
                end
                check({t, ".rd_dbg"}, bus.rd_dbg, e.dbg);
            end else if (done) begin
                break;
            end
            cyc++;
            if (cyc > MAX_CYC) begin
                n_checks++;
                $display("FAIL timeout: got %0d cycles expected at most %0d", cyc, MAX_CYC);
                break;
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Driver
    initial begin
        cnt   = 0;
        mbusy = '0;
        idle();
        bus.we = 1'b0; bus.wa = '0; bus.wd = '0; bus.iss_valid = 1'b0;
        bus.iss_rd = '0; bus.ra = '0; bus.ra_dbg = '0;

        // Reset held with junk on the write and issue ports
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(NREG - 1);
            s_rstn = 1'b0;
            drive("reset");
        end

        // Init sweep: reads gated, writes dropped (r7 at cycle 10)
        for (int i = 0; i < NREG; i++) begin
            randomize_inputs(NREG - 1);
            if (i == 10) begin
                s_we = 1'b1; s_wa = 7; s_wd = 32'h55; s_iss = 1'b1; s_iss_rd = 7;
            end
            drive("init");
        end

        idle(); s_ra[0] = 2; s_ra[1] = 3; s_dbg = 5; drive("init_vals");
        idle(); s_ra[0] = 7; s_ra[1] = 7; s_dbg = 7; drive("init_drop");

        // Write-first bypass then array read-back
        idle(); s_we = 1'b1; s_wa = 5; s_wd = 32'hdeadbeef; s_ra[0] = 5; s_ra[1] = 4; drive("bypass");
        idle(); s_ra[0] = 5; s_ra[1] = 5; s_dbg = 5; drive("readback");

        // Writes to x0 are no-ops
        idle(); s_we = 1'b1; s_wa = 0; s_wd = 32'h1234; drive("x0_wr");
        idle(); s_dbg = 0; drive("x0_after");

        // Scoreboard set, bypassed clear, and set-wins collision
        idle(); s_iss = 1'b1; s_iss_rd = 8; drive("sb_iss");
        idle(); s_ra[0] = 8; s_ra[1] = 8; drive("sb_busy");
        idle(); s_we = 1'b1; s_wa = 8; s_wd = 32'h88; s_ra[0] = 8; drive("sb_clr");
        idle(); s_ra[0] = 8; drive("sb_stay0");
        idle(); s_iss = 1'b1; s_iss_rd = 8; drive("sb_iss2");
        idle(); s_iss = 1'b1; s_iss_rd = 8; s_we = 1'b1; s_wa = 8; s_wd = 32'h99; s_ra[1] = 8; drive("sb_both");
        idle(); s_ra[0] = 8; s_ra[1] = 8; s_dbg = 8; drive("sb_setwin");
        idle(); s_iss = 1'b1; s_iss_rd = 0; s_ra[0] = 0; drive("sb_x0");

        // Random traffic over a narrow address range to force collisions
        for (int i = 0; i < 400; i++) begin
            randomize_inputs(11);
            drive("rand");
        end

        // Reset mid-RUN after writing r9
        idle(); s_we = 1'b1; s_wa = 9; s_wd = 32'hff; drive("r9_wr");
        idle(); s_ra[0] = 9; s_iss = 1'b1; s_iss_rd = 9; drive("r9_rd");
        idle(); s_rstn = 1'b0; s_ra[0] = 9; s_ra[1] = 2; s_dbg = 9; drive("rerst");
        for (int i = 0; i < NREG; i++) begin
            randomize_inputs(NREG - 1);
            drive("resweep");
        end
        idle(); s_ra[0] = 9; s_ra[1] = 3; s_dbg = 9; drive("r9_clean");

        for (int i = 0; i < 200; i++) begin
            randomize_inputs(NREG - 1);
            drive("rand2");
        end

        done = 1'b1;
    end
endmodule
